// File: rtl/bit_plane_feeder.sv
// Bit-serial feeder: latches one word per row and streams it MSB-first, one bit-plane
// per cycle, framing the downstream shift-accumulator with start_acc and result_valid.
module bit_plane_feeder #(
   parameter int ROWS    = 64,
   parameter int IN_BITS = 8,
   parameter int SIGNED  = 1
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [ROWS*IN_BITS-1:0]                          in_data,
   output logic                                             start_acc,
   output logic [ROWS-1:0]                                  bit_vec,
   output logic                                             bit_valid,
   output logic [((IN_BITS > 1) ? $clog2(IN_BITS) : 1)-1:0] bit_idx,
   output logic                                             msb_neg,
   output logic                                             busy,
   output logic                                             result_valid
);

   localparam int IDXW = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;

   typedef enum logic [1:0] {IDLE, START, SHIFT} state_e;

   state_e              state_q;
   logic                in_ready_q;
   logic                start_acc_q;
   logic [ROWS-1:0]     bit_vec_q;
   logic                bit_valid_q;
   logic [IDXW-1:0]     bit_idx_q;
   logic                msb_neg_q;
   logic                busy_q;
   logic                last_q;
   logic                result_valid_q;
   logic [IN_BITS-1:0]  sreg_q [ROWS];

   logic                xfer_d;
   logic                last_plane_d;
   logic [ROWS-1:0]     plane_d;
   logic [IN_BITS-1:0]  sreg_shift_d [ROWS];
   logic [IN_BITS-1:0]  word_d [ROWS];

   always_comb begin
      xfer_d       = in_valid && in_ready_q;
      last_plane_d = bit_valid_q && (bit_idx_q == '0);
      plane_d      = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         plane_d[r]      = sreg_q[r][IN_BITS-1];
         sreg_shift_d[r] = sreg_q[r] << 1;
         word_d[r]       = in_data[r*IN_BITS +: IN_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         in_ready_q     <= 1'b1;
         start_acc_q    <= 1'b0;
         bit_vec_q      <= '0;
         bit_valid_q    <= 1'b0;
         bit_idx_q      <= '0;
         msb_neg_q      <= 1'b0;
         busy_q         <= 1'b0;
         last_q         <= 1'b0;
         result_valid_q <= 1'b0;
         for (int unsigned r = 0; r < ROWS; r++) sreg_q[r] <= '0;
      end else begin
         // Result flag trails the last plane by two edges regardless of FSM state
         last_q         <= last_plane_d;
         result_valid_q <= last_q;
         start_acc_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (xfer_d) begin
                  for (int unsigned r = 0; r < ROWS; r++) sreg_q[r] <= word_d[r];
                  state_q     <= START;
                  start_acc_q <= 1'b1;
                  in_ready_q  <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            START: begin
               state_q     <= SHIFT;
               bit_valid_q <= 1'b1;
               bit_idx_q   <= IDXW'(IN_BITS - 1);
               bit_vec_q   <= plane_d;
               msb_neg_q   <= (SIGNED != 0);
               in_ready_q  <= (IN_BITS == 1);
               for (int unsigned r = 0; r < ROWS; r++) sreg_q[r] <= sreg_shift_d[r];
            end
            SHIFT: begin
               if (bit_idx_q == '0) begin
                  bit_valid_q <= 1'b0;
                  bit_vec_q   <= '0;
                  msb_neg_q   <= 1'b0;
                  if (xfer_d) begin
                     for (int unsigned r = 0; r < ROWS; r++) sreg_q[r] <= word_d[r];
                     state_q     <= START;
                     start_acc_q <= 1'b1;
                     in_ready_q  <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  bit_idx_q  <= bit_idx_q - IDXW'(1);
                  bit_vec_q  <= plane_d;
                  msb_neg_q  <= 1'b0;
                  in_ready_q <= (bit_idx_q == IDXW'(1));
                  for (int unsigned r = 0; r < ROWS; r++) sreg_q[r] <= sreg_shift_d[r];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign start_acc    = start_acc_q;
   assign bit_vec      = bit_vec_q;
   assign bit_valid    = bit_valid_q;
   assign bit_idx      = bit_idx_q;
   assign msb_neg      = msb_neg_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;

endmodule
